// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: EXE operand forwarding, load-use stall sequencing,
// redirect flushes and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] ex_waddr,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_waddr,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    input  logic                  wb_reg_write,
    input  logic                  redirect,
    input  logic                  cnt_clr,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_bubble,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_mem,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall_busy,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [2:0] LAT_M1_C = 3'(LOAD_LAT - 1);
    localparam logic       MULTI_C  = (LOAD_LAT > 1);
    localparam logic [REG_ADDR_W-1:0] R0_C = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t          state_r;
    state_t          state_nxt_s;
    logic [2:0]      scnt_r;
    logic [2:0]      scnt_nxt_s;
    logic            hazard_s;
    logic            stall_s;
    logic            flush_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // MEM result is younger than WB data, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] m_wa,
        input logic                  w_we,
        input logic [REG_ADDR_W-1:0] w_wa
    );
        logic [1:0] sel;
        if (m_we && (m_wa != R0_C) && (m_wa == src)) begin
            sel = 2'b10;
        end else if (w_we && (w_wa != R0_C) && (w_wa == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Operand forwarding selects for both EXE sources.
    always_comb begin
        fwd_a = fwd_sel(ex_rs, mem_reg_write, mem_waddr, wb_reg_write, wb_waddr);
        fwd_b = fwd_sel(ex_rt, mem_reg_write, mem_waddr, wb_reg_write, wb_waddr);
    end

    // Load-use hazard detection against the load sitting in EXE.
    always_comb begin
        hazard_s = ex_mem_read && ex_reg_write && (ex_waddr != R0_C) &&
                   ((id_rs_used && (id_rs == ex_waddr)) ||
                    (id_rt_used && (id_rt == ex_waddr)));
    end

    // Stall sequencer next state; redirect beats any stall, disable freezes everything.
    always_comb begin
        state_nxt_s = state_r;
        scnt_nxt_s  = scnt_r;
        stall_s     = 1'b0;
        flush_s     = 1'b0;
        if (!enable) begin
            state_nxt_s = state_r;
        end else if (redirect) begin
            flush_s     = 1'b1;
            state_nxt_s = IDLE;
            scnt_nxt_s  = 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hazard_s) begin
                        stall_s = 1'b1;
                        if (MULTI_C) begin
                            state_nxt_s = STALL;
                            scnt_nxt_s  = LAT_M1_C;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                STALL: begin
                    stall_s = 1'b1;
                    if (scnt_r <= 3'd1) begin
                        state_nxt_s = IDLE;
                        scnt_nxt_s  = 3'd0;
                    end else begin
                        scnt_nxt_s  = scnt_r - 3'd1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    scnt_nxt_s  = 3'd0;
                end
            endcase
        end
    end

    // Pipeline control outputs derived from the cycle's stall/flush decision.
    always_comb begin
        pc_en        = enable && !stall_s;
        if_id_en     = enable && !stall_s;
        id_ex_bubble = stall_s;
        flush_if_id  = flush_s;
        flush_id_ex  = flush_s;
        flush_ex_mem = flush_s;
        stall_busy   = (state_r == STALL);
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= IDLE;
            scnt_r  <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            scnt_r  <= scnt_nxt_s;
        end
    end

    // Saturating performance counters; clear outranks counting and enable.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt_r != CNT_MAX_C)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE_C;
            end
            if (flush_s && (flush_cnt_r != CNT_MAX_C)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE_C;
            end
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign flush_events = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances (LOAD_LAT 1/3/4) share
// one stimulus; a vector table covers combinational behaviour, sequences cover timing.
module tb_pipe_hazard_ctrl;

    logic clk, arst_n, enable, redirect, cnt_clr;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_waddr, mem_waddr, wb_waddr;
    logic id_rs_used, id_rt_used, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;

    logic pc_1, ifid_1, bub_1, fif_1, fie_1, fem_1, busy_1;
    logic [1:0] fa_1, fb_1, sc_1, fe_1;
    logic pc_3, ifid_3, bub_3, fif_3, fie_3, fem_3, busy_3;
    logic [1:0] fa_3, fb_3;
    logic [15:0] sc_3, fe_3;
    logic pc_4, ifid_4, bub_4, fif_4, fie_4, fem_4, busy_4;
    logic [1:0] fa_4, fb_4;
    logic [15:0] sc_4, fe_4;

    int n_vec = 0;
    int n_bad = 0;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(2)) u1 (
        .clk(clk), .arst_n(arst_n), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_waddr(ex_waddr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_waddr(mem_waddr), .mem_reg_write(mem_reg_write), .wb_waddr(wb_waddr),
        .wb_reg_write(wb_reg_write), .redirect(redirect), .cnt_clr(cnt_clr),
        .pc_en(pc_1), .if_id_en(ifid_1), .id_ex_bubble(bub_1), .flush_if_id(fif_1),
        .flush_id_ex(fie_1), .flush_ex_mem(fem_1), .fwd_a(fa_1), .fwd_b(fb_1),
        .stall_busy(busy_1), .stall_cycles(sc_1), .flush_events(fe_1));

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(16)) u3 (
        .clk(clk), .arst_n(arst_n), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_waddr(ex_waddr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_waddr(mem_waddr), .mem_reg_write(mem_reg_write), .wb_waddr(wb_waddr),
        .wb_reg_write(wb_reg_write), .redirect(redirect), .cnt_clr(cnt_clr),
        .pc_en(pc_3), .if_id_en(ifid_3), .id_ex_bubble(bub_3), .flush_if_id(fif_3),
        .flush_id_ex(fie_3), .flush_ex_mem(fem_3), .fwd_a(fa_3), .fwd_b(fb_3),
        .stall_busy(busy_3), .stall_cycles(sc_3), .flush_events(fe_3));

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(4), .CNT_W(16)) u4 (
        .clk(clk), .arst_n(arst_n), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_waddr(ex_waddr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_waddr(mem_waddr), .mem_reg_write(mem_reg_write), .wb_waddr(wb_waddr),
        .wb_reg_write(wb_reg_write), .redirect(redirect), .cnt_clr(cnt_clr),
        .pc_en(pc_4), .if_id_en(ifid_4), .id_ex_bubble(bub_4), .flush_if_id(fif_4),
        .flush_id_ex(fie_4), .flush_ex_mem(fem_4), .fwd_a(fa_4), .fwd_b(fb_4),
        .stall_busy(busy_4), .stall_cycles(sc_4), .flush_events(fe_4));

    typedef struct {
        string      name;
        logic       en, rd;
        logic [4:0] irs, irt;
        logic       rsu, rtu;
        logic [4:0] ers, ert, ewa;
        logic       erw, emr;
        logic [4:0] mwa;
        logic       mrw;
        logic [4:0] wwa;
        logic       wrw;
        logic [1:0] e_fa, e_fb;
        logic       e_pc, e_bub, e_fl;
    } vec_t;

    vec_t vecs[14];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        enable = 1'b1; redirect = 1'b0; cnt_clr = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_waddr = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_waddr = 5'd0; mem_reg_write = 1'b0; wb_waddr = 5'd0; wb_reg_write = 1'b0;
    endtask

    task automatic set_haz();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_waddr = 5'd5;
        id_rs = 5'd5; id_rs_used = 1'b1;
    endtask

    task automatic clr_haz();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_waddr = 5'd0;
        id_rs = 5'd0; id_rs_used = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        enable = v.en; redirect = v.rd; id_rs = v.irs; id_rt = v.irt;
        id_rs_used = v.rsu; id_rt_used = v.rtu; ex_rs = v.ers; ex_rt = v.ert;
        ex_waddr = v.ewa; ex_reg_write = v.erw; ex_mem_read = v.emr;
        mem_waddr = v.mwa; mem_reg_write = v.mrw; wb_waddr = v.wwa; wb_reg_write = v.wrw;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        set_idle();
        arst_n = 1'b0;
        #1;
        arst_n = 1'b1;
    endtask

    initial begin
        //          name          en    rd    irs    irt    rsu   rtu   ers    ert    ewa    erw   emr   mwa    mrw   wwa    wrw   fa     fb     pc    bub   fl
        vecs[0]  = '{"fwd_mem_a",  1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd3, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{"fwd_wb_a",   1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd3, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{"fwd_r0",     1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"fwd_b_mem",  1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 5'd2, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{"fwd_both",   1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd4, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{"haz_rs",     1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{"haz_rt",     1'b1, 1'b0, 5'd4, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{"nohaz_unus", 1'b1, 1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{"nohaz_nold", 1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{"nohaz_r0",   1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{"nohaz_norw", 1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{"redir_haz",  1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{"dis_haz",    1'b0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{"dis_redir",  1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

        // Reset state
        set_idle();
        arst_n = 1'b0;
        #1;
        chk("rst_sc", 32'(sc_1), 32'd0);
        chk("rst_fe", 32'(fe_1), 32'd0);
        chk("rst_busy3", 32'(busy_3), 32'd0);
        chk("rst_pc3", 32'(pc_3), 32'd1);
        @(negedge clk);
        arst_n = 1'b1;

        // Combinational table on the single-cycle-latency instance
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            chk({vecs[i].name, "/fwd_a"}, 32'(fa_1), 32'(vecs[i].e_fa));
            chk({vecs[i].name, "/fwd_b"}, 32'(fb_1), 32'(vecs[i].e_fb));
            chk({vecs[i].name, "/pc_en"}, 32'(pc_1), 32'(vecs[i].e_pc));
            chk({vecs[i].name, "/if_id_en"}, 32'(ifid_1), 32'(vecs[i].e_pc));
            chk({vecs[i].name, "/bubble"}, 32'(bub_1), 32'(vecs[i].e_bub));
            chk({vecs[i].name, "/flush"}, 32'({fif_1, fie_1, fem_1}), 32'({3{vecs[i].e_fl}}));
        end
        @(negedge clk);
        set_idle();
        #1;
        chk("tbl_stall_cnt", 32'(sc_1), 32'd2);
        chk("tbl_flush_cnt", 32'(fe_1), 32'd1);

        // Counter clear, saturation and clear priority (CNT_W=2)
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        chk("clr_sc", 32'(sc_1), 32'd0);
        chk("clr_fe", 32'(fe_1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            redirect = 1'b1;
        end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("fe_sat", 32'(fe_1), 32'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_haz();
        end
        @(negedge clk);
        clr_haz();
        #1;
        chk("sc_sat", 32'(sc_1), 32'd3);
        @(negedge clk);
        redirect = 1'b1;
        cnt_clr = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        cnt_clr = 1'b0;
        #1;
        chk("clr_over_redir", 32'(fe_1), 32'd0);
        chk("clr_sc2", 32'(sc_1), 32'd0);
        @(negedge clk);
        redirect = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        enable = 1'b0;
        cnt_clr = 1'b1;
        #1;
        chk("fe_before_dis_clr", 32'(fe_1), 32'd1);
        @(negedge clk);
        enable = 1'b1;
        cnt_clr = 1'b0;
        #1;
        chk("clr_while_dis", 32'(fe_1), 32'd0);

        // Single-cycle and three-cycle load-use stalls
        pulse_reset();
        @(negedge clk);
        set_haz();
        #1;
        chk("l1_c1_pc", 32'(pc_1), 32'd0);
        chk("l1_c1_bub", 32'(bub_1), 32'd1);
        chk("l3_c1_pc", 32'(pc_3), 32'd0);
        chk("l3_c1_busy", 32'(busy_3), 32'd0);
        @(negedge clk);
        clr_haz();
        #1;
        chk("l1_c2_pc", 32'(pc_1), 32'd1);
        chk("l1_c2_bub", 32'(bub_1), 32'd0);
        chk("l3_c2_bub", 32'(bub_3), 32'd1);
        chk("l3_c2_busy", 32'(busy_3), 32'd1);
        @(negedge clk);
        #1;
        chk("l3_c3_pc", 32'(pc_3), 32'd0);
        chk("l3_c3_busy", 32'(busy_3), 32'd1);
        @(negedge clk);
        #1;
        chk("l3_c4_pc", 32'(pc_3), 32'd1);
        chk("l3_c4_busy", 32'(busy_3), 32'd0);
        chk("l1_stall_cnt", 32'(sc_1), 32'd1);
        chk("l3_stall_cnt", 32'(sc_3), 32'd3);

        // Redirect in the second cycle of a four-cycle stall
        pulse_reset();
        @(negedge clk);
        set_haz();
        #1;
        chk("l4_c1_pc", 32'(pc_4), 32'd0);
        @(negedge clk);
        clr_haz();
        redirect = 1'b1;
        #1;
        chk("l4_redir_flush", 32'({fif_4, fie_4, fem_4}), 32'd7);
        chk("l4_redir_pc", 32'(pc_4), 32'd1);
        chk("l4_redir_bub", 32'(bub_4), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("l4_after_busy", 32'(busy_4), 32'd0);
        chk("l4_after_pc", 32'(pc_4), 32'd1);
        chk("l4_after_fe", 32'(fe_4), 32'd1);
        chk("l4_after_sc", 32'(sc_4), 32'd1);

        // Reset asserted in the middle of a stall
        pulse_reset();
        @(negedge clk);
        set_haz();
        @(negedge clk);
        clr_haz();
        #1;
        chk("mid_busy", 32'(busy_4), 32'd1);
        #1;
        arst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_4), 32'd0);
        chk("mid_rst_sc", 32'(sc_4), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        chk("post_rst_pc", 32'(pc_4), 32'd1);
        chk("post_rst_busy", 32'(busy_4), 32'd0);

        // Enable gating around a hazard and mid-stall
        pulse_reset();
        @(negedge clk);
        set_haz();
        enable = 1'b0;
        #1;
        chk("dis_pc", 32'(pc_3), 32'd0);
        chk("dis_bub", 32'(bub_3), 32'd0);
        @(negedge clk);
        #1;
        chk("dis_sc", 32'(sc_3), 32'd0);
        chk("dis_busy", 32'(busy_3), 32'd0);
        @(negedge clk);
        enable = 1'b1;
        #1;
        chk("en_c1_bub", 32'(bub_3), 32'd1);
        @(negedge clk);
        clr_haz();
        enable = 1'b0;
        #1;
        chk("pause_bub", 32'(bub_3), 32'd0);
        chk("pause_busy", 32'(busy_3), 32'd1);
        @(negedge clk);
        enable = 1'b1;
        #1;
        chk("resume_bub", 32'(bub_3), 32'd1);
        chk("resume_sc", 32'(sc_3), 32'd1);
        @(negedge clk);
        #1;
        chk("resume2_bub", 32'(bub_3), 32'd1);
        @(negedge clk);
        #1;
        chk("resume_end_pc", 32'(pc_3), 32'd1);
        chk("resume_end_busy", 32'(busy_3), 32'd0);
        chk("resume_end_sc", 32'(sc_3), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
